// File: rtl/acc_result_drain.sv
// acc_result_drain
//   Drains the weight accumulator array of the MatMul temporal-LUT datapath.
//   A drain request snapshots every accumulator sum into shadow registers and
//   sends the accumulator a one-cycle clear, so the next accumulation can start
//   at once. The snapshot is then streamed out one element per beat over a
//   valid/ready interface. Each beat is arithmetic-right-shifted and then
//   saturated to a signed OUT_WIDTH value.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   start_drain  single-cycle request: the values on sum_in are final
//   sum_in       NUM_ELEM packed signed sums, element 0 in the LSBs
//   acc_clear    one-cycle clear pulse to the accumulator
//   busy         high from capture until the end of the DONE state
//   out_valid / out_ready / out_data / out_idx / out_last / out_sat
//                result stream, one element per beat
//   done         one-cycle pulse after the last beat is accepted
//   overrun      one-cycle pulse when start_drain arrives while busy
module acc_result_drain #(
  parameter int NUM_ELEM  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0,
  parameter int IDX_W     = $clog2(NUM_ELEM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_drain,
  input  logic [NUM_ELEM*ACC_WIDTH-1:0] sum_in,
  output logic                          acc_clear,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          out_sat,
  output logic                          done,
  output logic                          overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  // Saturation bounds expressed at accumulator width so the comparison is
  // made on the full shifted value.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [ACC_WIDTH-1:0]   shadow_reg [NUM_ELEM];
  logic [ACC_WIDTH-1:0]   sum_elem   [NUM_ELEM];
  logic                   acc_clear_reg;
  logic                   overrun_reg;

  logic                   capture;
  logic                   streaming;
  logic signed [ACC_WIDTH-1:0] cur_sum;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]   sat_data;
  logic                   sat_flag;

  // Unpack the flat accumulator bus into per-lane words.
  for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_unpack
    assign sum_elem[gi] = sum_in[gi*ACC_WIDTH +: ACC_WIDTH];
  end

  // A request is honoured only in IDLE; while busy it is reported as overrun.
  assign capture   = (state_reg == IDLE) && start_drain;
  assign streaming = (state_reg == STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      acc_clear_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      // The snapshot is taken on the same edge that raises acc_clear, so the
      // accumulator only zeroes one edge after its sums are safely held.
      acc_clear_reg <= capture;
      overrun_reg   <= start_drain && (state_reg != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        shadow_reg[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        shadow_reg[k] <= sum_elem[k];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (start_drain) begin
          state_next = STREAM;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat arithmetic: sign-preserving shift, then clamp to the output range.
  always_comb begin
    cur_sum  = shadow_reg[idx_reg];
    shifted  = cur_sum >>> SHIFT;
    sat_data = shifted[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_data = OUT_MAX;
      sat_flag = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_data = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  // Beat fields are forced to zero outside STREAM so that reset clears them
  // immediately along with the state register.
  assign acc_clear = acc_clear_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign out_valid = streaming;
  assign out_data  = streaming ? sat_data : '0;
  assign out_idx   = streaming ? idx_reg : '0;
  assign out_last  = streaming && (idx_reg == LAST_IDX);
  assign out_sat   = streaming && sat_flag;

endmodule
